// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
//
// Puts the CPU's instruction-fetch port and data-memory port onto one shared
// memory bus that allows a single outstanding access. When a pipeline advance
// issues requests, the block holds the pipeline with cpu_stall. It serves the
// DM access first and then the IM access. It then releases the pipeline for
// one cycle (DONE), with both results held stable.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   im_*              instruction read request, byte address, size code
//   dm_*              data read/write request, address, write data, size code
//   im_dataout        last fetched instruction (registered)
//   dm_dataout        last data read result (registered)
//   cpu_stall         combinational pipeline hold
//   mem_req/we/addr/wdata/type   registered bus request fields
//   mem_ready/rdata   bus completion strobe and read data
//   stall_cnt         saturating count of cycles with cpu_stall high

module cpu_mem_arbiter #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    // CPU side
    input  logic                 im_read_mem,
    input  logic [ADDR_SIZE-1:0] im_addr,
    input  logic [2:0]           im_core_type,
    input  logic                 dm_read_mem,
    input  logic                 dm_write_mem,
    input  logic [ADDR_SIZE-1:0] dm_addr,
    input  logic [DATA_SIZE-1:0] dm_datain,
    input  logic [2:0]           dm_core_type,
    output logic [DATA_SIZE-1:0] im_dataout,
    output logic [DATA_SIZE-1:0] dm_dataout,
    output logic                 cpu_stall,
    // Bus side
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    output logic [2:0]           mem_type,
    input  logic                 mem_ready,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    // Statistics
    output logic [31:0]          stall_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StDmAcc,
        StImAcc,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Holding registers, captured in IDLE on the request edge
    logic                 im_p_q, im_p_d;
    logic                 dm_p_q, dm_p_d;
    logic                 dm_w_q, dm_w_d;
    logic [ADDR_SIZE-1:0] im_addr_q, im_addr_d;
    logic [2:0]           im_type_q, im_type_d;
    logic [ADDR_SIZE-1:0] dm_addr_q, dm_addr_d;
    logic [2:0]           dm_type_q, dm_type_d;
    logic [DATA_SIZE-1:0] dm_wdata_q, dm_wdata_d;

    // Result registers
    logic [DATA_SIZE-1:0] im_dataout_q, im_dataout_d;
    logic [DATA_SIZE-1:0] dm_dataout_q, dm_dataout_d;

    // Registered bus fields
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]           mem_type_q, mem_type_d;

    logic [31:0]          stall_cnt_q, stall_cnt_d;

    logic dm_any;
    logic req_any;

    assign dm_any  = dm_read_mem | dm_write_mem;
    assign req_any = dm_any | im_read_mem;

    // Combinational so the CPU freezes in the same cycle it raises a request.
    // Gated by rst because the state register alone cannot mask live requests.
    assign cpu_stall = !rst && (((state_q == StIdle) && req_any) ||
                                (state_q == StDmAcc) || (state_q == StImAcc));

    // Next-state, holding and result logic
    always_comb begin
        state_d      = state_q;
        im_p_d       = im_p_q;
        dm_p_d       = dm_p_q;
        dm_w_d       = dm_w_q;
        im_addr_d    = im_addr_q;
        im_type_d    = im_type_q;
        dm_addr_d    = dm_addr_q;
        dm_type_d    = dm_type_q;
        dm_wdata_d   = dm_wdata_q;
        im_dataout_d = im_dataout_q;
        dm_dataout_d = dm_dataout_q;

        case (state_q)
            StIdle: begin
                if (req_any) begin
                    im_p_d     = im_read_mem;
                    dm_p_d     = dm_any;
                    // Read and write together is treated as a write
                    dm_w_d     = dm_write_mem;
                    im_addr_d  = im_addr;
                    im_type_d  = im_core_type;
                    dm_addr_d  = dm_addr;
                    dm_type_d  = dm_core_type;
                    dm_wdata_d = dm_datain;
                    state_d    = dm_any ? StDmAcc : StImAcc;
                end
            end
            StDmAcc: begin
                if (mem_ready) begin
                    if (dm_p_q && !dm_w_q) begin
                        dm_dataout_d = mem_rdata;
                    end
                    state_d = im_p_q ? StImAcc : StDone;
                end
            end
            StImAcc: begin
                if (mem_ready) begin
                    im_dataout_d = mem_rdata;
                    state_d      = StDone;
                end
            end
            StDone: begin
                // Requests in this cycle are stale; the CPU gates them off
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bus fields are computed from the next state so they are registered yet
    // valid in the first cycle of each access state. The holding values only
    // change on the IDLE edge, which keeps the fields stable until mem_ready.
    always_comb begin
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_type_d  = 3'd0;

        case (state_d)
            StDmAcc: begin
                mem_req_d   = 1'b1;
                mem_we_d    = dm_w_d;
                mem_addr_d  = dm_addr_d;
                mem_wdata_d = dm_wdata_d;
                mem_type_d  = dm_type_d;
            end
            StImAcc: begin
                mem_req_d   = 1'b1;
                mem_addr_d  = im_addr_d;
                mem_type_d  = im_type_d;
            end
            default: begin
            end
        endcase
    end

    // Saturating stall counter
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cpu_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            im_p_q       <= 1'b0;
            dm_p_q       <= 1'b0;
            dm_w_q       <= 1'b0;
            im_addr_q    <= '0;
            im_type_q    <= 3'd0;
            dm_addr_q    <= '0;
            dm_type_q    <= 3'd0;
            dm_wdata_q   <= '0;
            im_dataout_q <= '0;
            dm_dataout_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_type_q   <= 3'd0;
            stall_cnt_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            im_p_q       <= im_p_d;
            dm_p_q       <= dm_p_d;
            dm_w_q       <= dm_w_d;
            im_addr_q    <= im_addr_d;
            im_type_q    <= im_type_d;
            dm_addr_q    <= dm_addr_d;
            dm_type_q    <= dm_type_d;
            dm_wdata_q   <= dm_wdata_d;
            im_dataout_q <= im_dataout_d;
            dm_dataout_q <= dm_dataout_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_type_q   <= mem_type_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign im_dataout = im_dataout_q;
    assign dm_dataout = dm_dataout_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_type   = mem_type_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Testbench for cpu_mem_arbiter: per-cycle vector table plus hand-written
// sequences for counter saturation and reset in the middle of an access.

module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_read_mem;
    logic [31:0] im_addr;
    logic [2:0]  im_core_type;
    logic        dm_read_mem;
    logic        dm_write_mem;
    logic [31:0] dm_addr;
    logic [31:0] dm_datain;
    logic [2:0]  dm_core_type;
    logic [31:0] im_dataout;
    logic [31:0] dm_dataout;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_type;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] stall_cnt;

    cpu_mem_arbiter #(
        .DATA_SIZE(32),
        .ADDR_SIZE(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .im_read_mem (im_read_mem),
        .im_addr     (im_addr),
        .im_core_type(im_core_type),
        .dm_read_mem (dm_read_mem),
        .dm_write_mem(dm_write_mem),
        .dm_addr     (dm_addr),
        .dm_datain   (dm_datain),
        .dm_core_type(dm_core_type),
        .im_dataout  (im_dataout),
        .dm_dataout  (dm_dataout),
        .cpu_stall   (cpu_stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_type    (mem_type),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // One row = inputs for one cycle and the outputs expected in that cycle
    typedef struct {
        logic        im_rd;
        logic [31:0] im_addr;
        logic [2:0]  im_type;
        logic        dm_rd;
        logic        dm_wr;
        logic [31:0] dm_addr;
        logic [31:0] dm_din;
        logic [2:0]  dm_type;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [2:0]  e_type;
        logic [31:0] e_im;
        logic [31:0] e_dm;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic add(input logic im_rd, input logic [31:0] ia, input logic [2:0] it,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dd, input logic [2:0] dt,
                       input logic rdy, input logic [31:0] rd,
                       input logic es, input logic erq, input logic ewe,
                       input logic [31:0] ea, input logic [31:0] ewd, input logic [2:0] et,
                       input logic [31:0] eim, input logic [31:0] edm, input logic [31:0] ec);
        vec_t v;
        v.im_rd = im_rd; v.im_addr = ia; v.im_type = it;
        v.dm_rd = dr; v.dm_wr = dw; v.dm_addr = da; v.dm_din = dd; v.dm_type = dt;
        v.rdy = rdy; v.rdata = rd;
        v.e_stall = es; v.e_req = erq; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ewd;
        v.e_type = et; v.e_im = eim; v.e_dm = edm; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        im_read_mem  = v.im_rd;
        im_addr      = v.im_addr;
        im_core_type = v.im_type;
        dm_read_mem  = v.dm_rd;
        dm_write_mem = v.dm_wr;
        dm_addr      = v.dm_addr;
        dm_datain    = v.dm_din;
        dm_core_type = v.dm_type;
        mem_ready    = v.rdy;
        mem_rdata    = v.rdata;
    endtask

    task automatic idle_inputs();
        im_read_mem = 0; im_addr = 0; im_core_type = 0;
        dm_read_mem = 0; dm_write_mem = 0; dm_addr = 0; dm_datain = 0; dm_core_type = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    initial begin
        // IM fetch, zero-wait (cycle 0 is IDLE with request)
        add(1, 'h10, 2, 0, 0, 0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 'h10, 2, 0, 0, 0, 0, 0, 1, 'h13,       1, 1, 0, 'h10, 0, 2, 0, 0, 1);
        add(1, 'h10, 2, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 'h13, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 'h13, 0, 2);
        // DM read then IM read, 2 wait cycles each
        add(1, 'h14, 4, 1, 0, 'h10004, 0, 1, 0, 0,    1, 0, 0, 0, 0, 0, 'h13, 0, 2);
        add(1, 'h14, 4, 1, 0, 'h10004, 0, 1, 0, 0,    1, 1, 0, 'h10004, 0, 1, 'h13, 0, 3);
        add(1, 'h14, 4, 1, 0, 'h10004, 0, 1, 0, 0,    1, 1, 0, 'h10004, 0, 1, 'h13, 0, 4);
        add(1, 'h14, 4, 1, 0, 'h10004, 0, 1, 1, 'hAAAA5555,
            1, 1, 0, 'h10004, 0, 1, 'h13, 0, 5);
        add(1, 'h14, 4, 1, 0, 'h10004, 0, 1, 0, 0,
            1, 1, 0, 'h14, 0, 4, 'h13, 'hAAAA5555, 6);
        add(1, 'h14, 4, 1, 0, 'h10004, 0, 1, 0, 0,
            1, 1, 0, 'h14, 0, 4, 'h13, 'hAAAA5555, 7);
        add(1, 'h14, 4, 1, 0, 'h10004, 0, 1, 1, 'h00400093,
            1, 1, 0, 'h14, 0, 4, 'h13, 'hAAAA5555, 8);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 'h00400093, 'hAAAA5555, 9);
        // DM write, 3 wait cycles; live inputs change under the access
        add(0, 0, 0, 0, 1, 'h20, 'hDEADBEEF, 2, 0, 0,
            1, 0, 0, 0, 0, 0, 'h00400093, 'hAAAA5555, 9);
        for (int k = 0; k < 4; k++) begin
            add(0, 'h99, 7, 0, 0, 'h77, 'h12345678, 5, (k == 3), 'hFFFF0000,
                1, 1, 1, 'h20, 'hDEADBEEF, 2, 'h00400093, 'hAAAA5555, 10 + k);
        end
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 'h00400093, 'hAAAA5555, 14);
        // Read and write together, no IM: single write access
        add(0, 'h44, 5, 1, 1, 'h30, 'h0BADF00D, 0, 0, 0,
            1, 0, 0, 0, 0, 0, 'h00400093, 'hAAAA5555, 14);
        add(0, 'h44, 5, 1, 1, 'h30, 'h0BADF00D, 0, 1, 'h5A5A5A5A,
            1, 1, 1, 'h30, 'h0BADF00D, 0, 'h00400093, 'hAAAA5555, 15);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 'h00400093, 'hAAAA5555, 16);
        // mem_ready in IDLE is ignored
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 'hFFFFFFFF,
            0, 0, 0, 0, 0, 0, 'h00400093, 'hAAAA5555, 16);
        // DM read + IM read, zero-wait: 3 stall cycles
        add(1, 'h18, 2, 1, 0, 'h40, 0, 2, 0, 0,
            1, 0, 0, 0, 0, 0, 'h00400093, 'hAAAA5555, 16);
        add(1, 'h18, 2, 1, 0, 'h40, 0, 2, 1, 'h11111111,
            1, 1, 0, 'h40, 0, 2, 'h00400093, 'hAAAA5555, 17);
        add(1, 'h18, 2, 1, 0, 'h40, 0, 2, 1, 'h22222222,
            1, 1, 0, 'h18, 0, 2, 'h00400093, 'h11111111, 18);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 'h22222222, 'h11111111, 19);

        // Reset state, with a request held high during reset
        idle_inputs();
        rst = 1'b1;
        im_read_mem = 1'b1;
        @(negedge clk);
        #1;
        chk("reset cpu_stall", {31'd0, cpu_stall}, 0);
        chk("reset mem_req", {31'd0, mem_req}, 0);
        chk("reset im_dataout", im_dataout, 0);
        chk("reset dm_dataout", dm_dataout, 0);
        chk("reset stall_cnt", stall_cnt, 0);
        im_read_mem = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("row%0d cpu_stall", i), {31'd0, cpu_stall}, {31'd0, vecs[i].e_stall});
            chk($sformatf("row%0d mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("row%0d mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
            chk($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            chk($sformatf("row%0d mem_type", i), {29'd0, mem_type}, {29'd0, vecs[i].e_type});
            chk($sformatf("row%0d im_dataout", i), im_dataout, vecs[i].e_im);
            chk($sformatf("row%0d dm_dataout", i), dm_dataout, vecs[i].e_dm);
            chk($sformatf("row%0d stall_cnt", i), stall_cnt, vecs[i].e_cnt);
        end

        // Saturation: preload the counter near the top, then stall 4 cycles
        @(negedge clk);
        idle_inputs();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.stall_cnt_q;
        @(negedge clk);
        im_read_mem = 1'b1;
        im_addr     = 32'h60;
        #1;
        chk("sat preload", stall_cnt, 32'hFFFF_FFFE);
        chk("sat stall", {31'd0, cpu_stall}, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            im_read_mem = 1'b0;
            mem_ready   = (k == 2);
            mem_rdata   = 32'h0000_0777;
            #1;
            chk($sformatf("sat cnt%0d", k), stall_cnt, 32'hFFFF_FFFF);
        end
        chk("sat im_dataout", im_dataout, 32'h0000_0777);
        chk("sat done stall", {31'd0, cpu_stall}, 0);

        // Reset in the middle of an IM access
        @(negedge clk);
        idle_inputs();
        im_read_mem  = 1'b1;
        im_addr      = 32'h50;
        im_core_type = 3'd2;
        @(negedge clk);
        #1;
        chk("mid req before rst", {31'd0, mem_req}, 1);
        chk("mid addr before rst", mem_addr, 32'h50);
        rst = 1'b1;
        #1;
        chk("mid rst mem_req", {31'd0, mem_req}, 0);
        chk("mid rst cpu_stall", {31'd0, cpu_stall}, 0);
        chk("mid rst im_dataout", im_dataout, 0);
        @(negedge clk);
        rst         = 1'b0;
        im_read_mem = 1'b0;
        mem_ready   = 1'b1;
        mem_rdata   = 32'h0000_CAFE;
        @(negedge clk);
        #1;
        chk("post rst im_dataout", im_dataout, 0);
        chk("post rst mem_req", {31'd0, mem_req}, 0);
        chk("post rst stall_cnt", stall_cnt, 0);
        chk("post rst cpu_stall", {31'd0, cpu_stall}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
